// File: rtl/rcas_arb_pkg.sv
// Shared constants and bundle types for the rcas arbiter.
// Imported by the datapath wrapper and its helpers.
package rcas_arb_pkg;

    localparam int DATA_W = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] result;
        logic              c_out;
        logic              ovf;
    } rsp_slot_t;

endpackage

// File: rtl/rcas_8bit.sv
// Ripple-carry add/subtract unit, 8 bits wide.
// sel=1 inverts b and injects a carry-in, so c_out=1 means no borrow.
module rcas_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sel,
    output logic [7:0] result,
    output logic       c_out
);

    logic [8:0] c;
    logic [7:0] bx;

    assign bx   = b ^ {8{sel}};
    assign c[0] = sel;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign result[i] = a[i] ^ bx[i] ^ c[i];
        assign c[i+1]    = (a[i] & bx[i])
                         | (c[i] & (a[i] ^ bx[i]));
    end

    assign c_out = c[8];

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with its priority pointer.
// The pointer flips to the loser after every grant.
module rr_arb2 #(
    parameter int PRIO_RESET = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            (elig == 2'b11): grant[ptr] = 1'b1;
            (elig == 2'b01): grant[0]   = 1'b1;
            (elig == 2'b10): grant[1]   = 1'b1;
            default:         grant      = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'(PRIO_RESET);
        end else if (grant[0]) begin
            ptr <= 1'b1;
        end else if (grant[1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/rcas_arbiter.sv
// Shares one rcas_8bit between two requesters with
// round-robin grant and a registered response slot each.
module rcas_arbiter
    import rcas_arb_pkg::*;
#(
    parameter int PRIO_RESET = 0,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_sel,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_c_out,
    output logic              rsp0_ovf,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_c_out,
    output logic              rsp1_ovf,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic              busy
);

    rsp_slot_t         slot [2];
    logic [CNT_W-1:0]  cnt  [2];
    logic [1:0]        rsp_rdy;
    logic [1:0]        elig;
    logic [1:0]        grant;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_sel;
    logic [DATA_W-1:0] sum;
    logic              c_out;
    logic              ovf;

    assign rsp_rdy = {rsp1_ready, rsp0_ready};

    // A slot draining this cycle can accept a new load.
    assign elig[0] = req0_valid
                   & (~slot[0].valid | rsp0_ready);
    assign elig[1] = req1_valid
                   & (~slot[1].valid | rsp1_ready);

    rr_arb2 #(
        .PRIO_RESET(PRIO_RESET)
    ) u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .elig (elig),
        .grant(grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign op_a   = grant[1] ? req1_a   : req0_a;
    assign op_b   = grant[1] ? req1_b   : req0_b;
    assign op_sel = grant[1] ? req1_sel : req0_sel;

    rcas_8bit u_alu (
        .a     (op_a),
        .b     (op_b),
        .sel   (op_sel),
        .result(sum),
        .c_out (c_out)
    );

    assign ovf = (op_a[7] == (op_b[7] ^ op_sel))
               && (sum[7] != op_a[7]);

    for (genvar i = 0; i < 2; i++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot[i] <= '0;
            end else if (grant[i]) begin
                slot[i] <= '{valid:  1'b1,
                             result: sum,
                             c_out:  c_out,
                             ovf:    ovf};
            end else if (slot[i].valid && rsp_rdy[i]) begin
                slot[i].valid <= 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt[i] <= '0;
            end else if (slot[i].valid && rsp_rdy[i]
                         && cnt[i] != {CNT_W{1'b1}}) begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign rsp0_valid  = slot[0].valid;
    assign rsp0_result = slot[0].result;
    assign rsp0_c_out  = slot[0].c_out;
    assign rsp0_ovf    = slot[0].ovf;
    assign rsp1_valid  = slot[1].valid;
    assign rsp1_result = slot[1].result;
    assign rsp1_c_out  = slot[1].c_out;
    assign rsp1_ovf    = slot[1].ovf;
    assign cnt0        = cnt[0];
    assign cnt1        = cnt[1];

    assign busy = slot[0].valid | slot[1].valid
                | req0_valid | req1_valid;

endmodule
